// File: rtl/degamma_pkg.sv
// Shared constants for the degamma_22 block: pixel width, knot table
// geometry, the 17-knot curve and the mode FSM state type.
package degamma_pkg;

  localparam int COLOR_DEPTH = 8;
  localparam int KNOT_COUNT  = 17;
  localparam int SEG_SHIFT   = 4;

  // Knot i sits at x = 16*i on the gamma-2.2 expansion curve. The last
  // knot is the extrapolated x = 256 point, so the table needs 9 bits.
  localparam logic [8:0] K [KNOT_COUNT] = '{
    9'd0,   9'd1,   9'd3,   9'd6,   9'd12,  9'd20,  9'd30,  9'd42,  9'd56,
    9'd73,  9'd91,  9'd113, 9'd137, 9'd163, 9'd192, 9'd223, 9'd257
  };

  // RUN: requested mode equals the active mode. PENDING: a switch is waiting
  // for an idle, drained pipeline.
  typedef enum logic {
    MODE_RUN     = 1'b0,
    MODE_PENDING = 1'b1
  } mode_state_t;

  // Knot lookup clamped to the table so a stray index can never read
  // past the final knot.
  function automatic logic [8:0] knotValue(input logic [4:0] idx);
    if (idx > 5'(KNOT_COUNT - 1)) begin
      return K[KNOT_COUNT-1];
    end
    return K[idx];
  endfunction

endpackage

// File: rtl/degamma_pwl_interp.sv
// Combinational halves of the piecewise-linear degamma curve:
// pixel -> {K[seg], d*frac} for the S2 registers, and the registered
// {base, product} -> rounded, saturated linear value for S3.
module degamma_pwl_interp
  import degamma_pkg::*;
(
  input  logic [COLOR_DEPTH-1:0] i_pixel,
  output logic [8:0]             o_base,
  output logic [8:0]             o_prod,
  input  logic [8:0]             i_base,
  input  logic [8:0]             i_prod,
  output logic [COLOR_DEPTH-1:0] o_y
);

  logic [3:0] w_seg;
  logic [3:0] w_frac;
  logic [8:0] w_hi;
  logic [8:0] w_delta;
  logic [9:0] w_round;
  logic [9:0] w_sum;

  // Segment lookup: slope between neighbouring knots (never above 34) times
  // the position inside the segment; 34*15 = 510 still fits in 9 bits.
  always_comb begin
    w_seg   = i_pixel[7:4];
    w_frac  = i_pixel[3:0];
    o_base  = knotValue({1'b0, w_seg});
    w_hi    = knotValue({1'b0, w_seg} + 5'd1);
    w_delta = w_hi - o_base;
    o_prod  = w_delta * {5'b0, w_frac};
  end

  // Round the product to the nearest step (one extra bit because p+8 can
  // reach 518), add the base knot and clamp at full scale.
  always_comb begin
    w_round = ({1'b0, i_prod} + 10'd8) >> SEG_SHIFT;
    w_sum   = {1'b0, i_base} + w_round;
    o_y     = (w_sum > 10'd255) ? 8'd255 : w_sum[7:0];
  end

endmodule

// File: rtl/degamma_22.sv
// Gamma-2.2 expander: three registered stages (input capture, knot lookup,
// interpolate/bypass select) with aligned sidebands and a mode FSM that
// only changes the active mode when the pipeline is idle and drained.
module degamma_22
  import degamma_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [COLOR_DEPTH-1:0] i_pixel,
  input  logic                   i_valid,
  input  logic [2:0]             i_color,
  input  logic                   i_last_pic,
  input  logic                   i_bypass,
  output logic [COLOR_DEPTH-1:0] o_pixel,
  output logic                   o_valid,
  output logic [2:0]             o_color,
  output logic                   o_last_pic,
  output logic                   o_busy,
  output logic                   o_mode_pending
);

  logic [COLOR_DEPTH-1:0] r_s1Pixel;
  logic                   r_s1Valid;
  logic [2:0]             r_s1Color;
  logic                   r_s1Last;
  logic                   r_s1Mode;

  logic [8:0]             r_s2Base;
  logic [8:0]             r_s2Prod;
  logic [COLOR_DEPTH-1:0] r_s2Pixel;
  logic                   r_s2Valid;
  logic [2:0]             r_s2Color;
  logic                   r_s2Last;
  logic                   r_s2Mode;

  logic [COLOR_DEPTH-1:0] r_s3Pixel;
  logic                   r_s3Valid;
  logic [2:0]             r_s3Color;
  logic                   r_s3Last;

  logic                   r_modeQ;
  logic                   w_modeNext;
  mode_state_t            w_state;
  logic                   w_busy;

  logic [8:0]             w_base;
  logic [8:0]             w_prod;
  logic [COLOR_DEPTH-1:0] w_y;

  degamma_pwl_interp u_interp (
    .i_pixel (r_s1Pixel),
    .o_base  (w_base),
    .o_prod  (w_prod),
    .i_base  (r_s2Base),
    .i_prod  (r_s2Prod),
    .o_y     (w_y)
  );

  assign w_busy = r_s1Valid | r_s2Valid | r_s3Valid;

  // S1: capture the incoming pixel, sidebands and the mode it will use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Pixel <= '0;
      r_s1Valid <= 1'b0;
      r_s1Color <= '0;
      r_s1Last  <= 1'b0;
      r_s1Mode  <= 1'b0;
    end else begin
      r_s1Pixel <= i_pixel;
      r_s1Valid <= i_valid;
      r_s1Color <= i_color;
      r_s1Last  <= i_last_pic;
      r_s1Mode  <= r_modeQ;
    end
  end

  // S2: register the knot base and slope product alongside the raw pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2Base  <= '0;
      r_s2Prod  <= '0;
      r_s2Pixel <= '0;
      r_s2Valid <= 1'b0;
      r_s2Color <= '0;
      r_s2Last  <= 1'b0;
      r_s2Mode  <= 1'b0;
    end else begin
      r_s2Base  <= w_base;
      r_s2Prod  <= w_prod;
      r_s2Pixel <= r_s1Pixel;
      r_s2Valid <= r_s1Valid;
      r_s2Color <= r_s1Color;
      r_s2Last  <= r_s1Last;
      r_s2Mode  <= r_s1Mode;
    end
  end

  // S3: pick the interpolated value or the untouched pixel for the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3Pixel <= '0;
      r_s3Valid <= 1'b0;
      r_s3Color <= '0;
      r_s3Last  <= 1'b0;
    end else begin
      r_s3Pixel <= r_s2Mode ? r_s2Pixel : w_y;
      r_s3Valid <= r_s2Valid;
      r_s3Color <= r_s2Color;
      r_s3Last  <= r_s2Last;
    end
  end

  // Mode FSM decode: a requested change is held until an idle input cycle
  // finds the pipeline empty, so no frame is split across modes.
  always_comb begin
    w_state    = (i_bypass != r_modeQ) ? MODE_PENDING : MODE_RUN;
    w_modeNext = r_modeQ;
    if ((w_state == MODE_PENDING) && !i_valid && !w_busy) begin
      w_modeNext = i_bypass;
    end
  end

  // Mode FSM register: the active mode itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_modeQ <= 1'b0;
    end else begin
      r_modeQ <= w_modeNext;
    end
  end

  assign o_pixel        = r_s3Pixel;
  assign o_valid        = r_s3Valid;
  assign o_color        = r_s3Color;
  assign o_last_pic     = r_s3Last;
  assign o_busy         = w_busy;
  assign o_mode_pending = (w_state == MODE_PENDING);

endmodule
